// File: rtl/dmem_pkg.sv
// Shared types, widths and lane helpers for the data-memory responder.
package dmem_pkg;

   localparam int XLEN   = 32;
   localparam int MASK_W = 4;
   localparam int CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } dmem_state_e;

   // Keep only the bytes whose lane enable is set; the rest read as zero.
   function automatic logic [XLEN-1:0] lane_select(input logic [XLEN-1:0]   data,
                                                   input logic [MASK_W-1:0] mask);
      logic [XLEN-1:0] result;
      result = '0;
      for (int i = 0; i < MASK_W; i++) begin
         if (mask[i]) result[8*i +: 8] = data[8*i +: 8];
      end
      return result;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage with a single byte-masked synchronous write port and a
// combinational read at the same index.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [XLEN-1:0]   i_wdata,
   input  logic [MASK_W-1:0] i_mask,
   output logic [XLEN-1:0]   o_rdata
);

   logic [XLEN-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int i = 0; i < MASK_W; i++) begin
            if (i_mask[i]) mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
         end
      end
   end

   assign o_rdata = mem[i_idx];

endmodule

// File: rtl/dmem_responder.sv
// Latency-bearing data-memory slave with valid/ready request and response
// handshakes, byte-lane masking and range/legality error reporting.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | ready for a request; captures it on i_req_valid
//   BUSY    | counting down the access latency; access happens when cnt==0
//   RESP    | response held on o_res_* until i_res_ready
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter int          LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_req_valid,
   output logic              o_req_ready,
   input  logic [XLEN-1:0]   i_req_addr,
   input  logic              i_req_ren,
   input  logic              i_req_wen,
   input  logic [XLEN-1:0]   i_req_wdata,
   input  logic [MASK_W-1:0] i_req_mask,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [XLEN-1:0]   o_res_rdata,
   output logic              o_res_err
);

   localparam int               IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   dmem_state_e       state;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   req_addr;
   logic              req_ren;
   logic              req_wen;
   logic [XLEN-1:0]   req_wdata;
   logic [MASK_W-1:0] req_mask;

   logic [XLEN-1:0]   offset;
   logic              in_range;
   logic              req_err;
   logic              access_now;
   logic              mem_we;
   logic [IDX_W-1:0]  mem_idx;
   logic [XLEN-1:0]   mem_rdata;

   // Range is judged on the full 32-bit offset so a wrapped subtraction or
   // a far address can never alias into the array after truncation.
   assign offset     = req_addr - BASE_ADDR;
   assign in_range   = (req_addr >= BASE_ADDR) && ((offset >> 2) < XLEN'(DEPTH_WORDS));
   assign req_err    = !in_range || (req_ren == req_wen) || (req_mask == '0);
   assign mem_idx    = offset[IDX_W+1:2];
   assign access_now = (state == ST_BUSY) && (cnt == '0);
   assign mem_we     = access_now && !i_rst && !req_err && req_wen;

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .IDX_W       (IDX_W)
   ) u_array (
      .i_clk   (i_clk),
      .i_we    (mem_we),
      .i_idx   (mem_idx),
      .i_wdata (req_wdata),
      .i_mask  (req_mask),
      .o_rdata (mem_rdata)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         req_addr    <= '0;
         req_ren     <= 1'b0;
         req_wen     <= 1'b0;
         req_wdata   <= '0;
         req_mask    <= '0;
         o_req_ready <= 1'b1;
         o_res_valid <= 1'b0;
         o_res_rdata <= '0;
         o_res_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_req_valid) begin
                  req_addr    <= i_req_addr;
                  req_ren     <= i_req_ren;
                  req_wen     <= i_req_wen;
                  req_wdata   <= i_req_wdata;
                  req_mask    <= i_req_mask;
                  cnt         <= CNT_LOAD;
                  o_req_ready <= 1'b0;
                  state       <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  o_res_valid <= 1'b1;
                  o_res_err   <= req_err;
                  o_res_rdata <= (req_err || req_wen) ? '0 : lane_select(mem_rdata, req_mask);
                  state       <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (i_res_ready) begin
                  o_res_valid <= 1'b0;
                  o_res_rdata <= '0;
                  o_res_err   <= 1'b0;
                  o_req_ready <= 1'b1;
                  state       <= ST_IDLE;
               end
            end
            default: begin
               o_req_ready <= 1'b1;
               state       <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
